mp_pi_mux: RTL and testbench

- Parametrised, time-multiplexed PI controller for NCH interleaved channels on one sample stream (one sample per clk, `sync` marks channel 0).
- Successor to the fixed two-channel (X/Y) magnitude/phase feedback processor. Generalised in channel count, data width, coefficient width and scaling shift.
- Adds an integrator-hold mode and sync-misalignment detection.
- Sits between the field-detection stream and the drive setpoint path. Per-channel config is written over the local-bus write strobe.

---
 rtl/mp_pi_mux.sv | 230 +++++++++++++++++++++++
 tb/tb_mp_pi_mux.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mp_pi_mux.sv
// mp_pi_mux: time-multiplexed PI controller for NCH interleaved channels.
// Three-stage pipeline with per-channel config, integrator hold and sync check.
module mp_pi_mux #(
  parameter int NCH   = 2,
  parameter int CW    = 4,
  parameter int DW    = 18,
  parameter int KW    = 18,
  parameter int SHIFT = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sync,
  input  logic signed [DW-1:0] in_mp,
  input  logic                 hold,
  input  logic                 lb_write,
  input  logic [CW+2:0]        lb_addr,
  input  logic [DW-1:0]        lb_data,
  output logic signed [DW-1:0] out_xy,
  output logic                 out_sync,
  output logic                 sync_err
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = DW + KW;

  localparam logic signed [DW:0] EMAX =
    {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0] EMIN =
    {2'b11, {(DW-1){1'b0}}};
  localparam logic signed [PW-1:0] PMAX =
    {{(PW-DW){1'b0}}, {DW{1'b1}}};
  localparam logic signed [PW-1:0] PMIN =
    {{(PW-DW){1'b1}}, {DW{1'b0}}};

  function automatic logic signed [DW-1:0] sat_e(
    input logic signed [DW:0] x
  );
    logic signed [DW:0] t;
    t = x;
    if (x > EMAX) t = EMAX;
    if (x < EMIN) t = EMIN;
    return t[DW-1:0];
  endfunction

  function automatic logic signed [DW:0] sat_p(
    input logic signed [PW-1:0] x
  );
    logic signed [PW-1:0] t;
    t = x;
    if (x > PMAX) t = PMAX;
    if (x < PMIN) t = PMIN;
    return t[DW:0];
  endfunction

  function automatic logic signed [DW+1:0] clip(
    input logic signed [DW+1:0] x,
    input logic signed [DW-1:0] lo,
    input logic signed [DW-1:0] hi
  );
    logic signed [DW+1:0] l;
    logic signed [DW+1:0] h;
    logic signed [DW+1:0] t;
    l = lo;
    h = hi;
    t = (x < l) ? l : x;
    return (t > h) ? h : t;
  endfunction

  logic [CW-1:0] cnt;
  logic [CW-1:0] ch;
  logic [IW-1:0] ci;
  logic          ch_ok;

  logic signed [DW-1:0] set_r [NCH];
  logic signed [KW-1:0] ki_r  [NCH];
  logic signed [KW-1:0] kp_r  [NCH];
  logic signed [DW-1:0] lhi_r [NCH];
  logic signed [DW-1:0] llo_r [NCH];
  logic signed [DW-1:0] acc_r [NCH];

  logic [CW-1:0] lb_ch;
  logic [2:0]    lb_reg;
  logic [IW-1:0] lb_ci;
  logic          lb_ok;

  logic                 s1_v, s1_sync;
  logic [IW-1:0]        s1_ci;
  logic signed [DW-1:0] s1_err, s1_lhi, s1_llo;
  logic signed [KW-1:0] s1_ki, s1_kp;

  logic                 s2_v, s2_sync;
  logic [IW-1:0]        s2_ci;
  logic signed [DW:0]   s2_pi, s2_pp;
  logic signed [DW-1:0] s2_lhi, s2_llo;

  logic signed [DW:0]   diff;
  logic signed [PW-1:0] prod_i, prod_p;
  logic signed [DW+1:0] a_x, pi_x, pp_x;
  logic signed [DW+1:0] cl_i, n_x, cl_o;
  logic signed [DW-1:0] acc_new;

  assign ch     = sync ? '0 : cnt;
  assign ci     = ch[IW-1:0];
  assign ch_ok  = {1'b0, ch} < (CW+1)'(NCH);
  assign lb_ch  = lb_addr[CW+2:3];
  assign lb_reg = lb_addr[2:0];
  assign lb_ci  = lb_ch[IW-1:0];
  assign lb_ok  = {1'b0, lb_ch} < (CW+1)'(NCH);

  // channel counter; a sync realigns it and flags an off-slot sync
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= sync && (cnt != '0);
      if (sync)
        cnt <= CW'(1);
      else if (cnt == CW'(NCH-1))
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
    end
  end

  // per-channel config registers written from the local bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        set_r[i] <= '0;
        ki_r[i]  <= '0;
        kp_r[i]  <= '0;
        lhi_r[i] <= '0;
        llo_r[i] <= '0;
      end
    end else if (lb_write && lb_ok) begin
      case (lb_reg)
        3'd0: set_r[lb_ci] <= lb_data;
        3'd1: ki_r[lb_ci]  <= lb_data[KW-1:0];
        3'd2: kp_r[lb_ci]  <= lb_data[KW-1:0];
        3'd3: lhi_r[lb_ci] <= lb_data;
        3'd4: llo_r[lb_ci] <= lb_data;
        default: ;
      endcase
    end
  end

  assign diff = {set_r[ci][DW-1], set_r[ci]}
              - {in_mp[DW-1], in_mp};

  // S1: config lookup and saturated error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_sync <= 1'b0;
      s1_ci   <= '0;
      s1_err  <= '0;
      s1_ki   <= '0;
      s1_kp   <= '0;
      s1_lhi  <= '0;
      s1_llo  <= '0;
    end else begin
      s1_v    <= ch_ok;
      s1_sync <= sync;
      s1_ci   <= ci;
      s1_err  <= sat_e(diff);
      s1_ki   <= ki_r[ci];
      s1_kp   <= kp_r[ci];
      s1_lhi  <= lhi_r[ci];
      s1_llo  <= llo_r[ci];
    end
  end

  assign prod_i = s1_err * s1_ki;
  assign prod_p = s1_err * s1_kp;

  // S2: scaled integral and proportional terms
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      s2_sync <= 1'b0;
      s2_ci   <= '0;
      s2_pi   <= '0;
      s2_pp   <= '0;
      s2_lhi  <= '0;
      s2_llo  <= '0;
    end else begin
      s2_v    <= s1_v;
      s2_sync <= s1_sync;
      s2_ci   <= s1_ci;
      s2_pi   <= sat_p(prod_i >>> SHIFT);
      s2_pp   <= sat_p(prod_p >>> SHIFT);
      s2_lhi  <= s1_lhi;
      s2_llo  <= s1_llo;
    end
  end

  // S3 arithmetic: clipped integrator update and output sum
  always_comb begin
    a_x     = acc_r[s2_ci];
    pi_x    = s2_pi;
    pp_x    = s2_pp;
    cl_i    = clip(a_x + pi_x, s2_llo, s2_lhi);
    acc_new = cl_i[DW-1:0];
    n_x     = acc_new;
    cl_o    = clip(n_x + pp_x, s2_llo, s2_lhi);
  end

  // S3: integrator write-back unless held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++)
        acc_r[i] <= '0;
    end else if (s2_v && !hold) begin
      acc_r[s2_ci] <= acc_new;
    end
  end

  // S3: registered outputs; bubbles after reset emit zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_xy   <= '0;
      out_sync <= 1'b0;
    end else begin
      out_xy   <= s2_v ? cl_o[DW-1:0] : '0;
      out_sync <= s2_v && s2_sync;
    end
  end

endmodule

// File: tb/tb_mp_pi_mux.sv
// tb_mp_pi_mux: directed scoreboard bench for mp_pi_mux.
// Stimulus queues expected outputs; a monitor pops them 3 clk later.
module tb_mp_pi_mux;

  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int DW  = 18;

  typedef struct {
    int    stamp;
    int    v;
    int    s;
    string nm;
  } item_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 sync = 1'b0;
  logic signed [DW-1:0] in_mp = '0;
  logic                 hold = 1'b0;
  logic                 lb_write = 1'b0;
  logic [CW+2:0]        lb_addr = '0;
  logic [DW-1:0]        lb_data = '0;
  logic signed [DW-1:0] out_xy;
  logic                 out_sync;
  logic                 sync_err;

  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  int    pos = 0;
  int    cur_in [NCH];
  int    exp_ch [NCH];
  item_t q [$];

  mp_pi_mux #(
    .NCH(NCH), .CW(CW), .DW(DW),
    .KW(18), .SHIFT(17)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync     (sync),
    .in_mp    (in_mp),
    .hold     (hold),
    .lb_write (lb_write),
    .lb_addr  (lb_addr),
    .lb_data  (lb_data),
    .out_xy   (out_xy),
    .out_sync (out_sync),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(
    input string nm, input int act, input int exp
  );
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endfunction

  // monitor: compare the output due this cycle
  always @(negedge clk) begin
    item_t it;
    if (q.size() > 0 && q[0].stamp <= cyc) begin
      it = q.pop_front();
      chk({it.nm, " out"}, int'(out_xy), it.v);
      chk({it.nm, " sync"}, int'(out_sync), it.s);
    end
  end

  task automatic step(input bit c, input bit fs);
    int ch;
    item_t it;
    ch = fs ? 0 : pos;
    in_mp = DW'(cur_in[ch]);
    sync = (ch == 0);
    if (c) begin
      it.stamp = cyc + 3;
      it.v = exp_ch[ch];
      it.s = (ch == 0) ? 1 : 0;
      it.nm = $sformatf("ch%0d@%0d", ch, cyc);
      q.push_back(it);
    end
    @(posedge clk);
    #1;
    lb_write = 1'b0;
    pos = (ch + 1) % NCH;
  endtask

  task automatic wr(input int ch, input int r,
                    input int d);
    while (pos != NCH - 1) step(0, 0);
    lb_write = 1'b1;
    lb_addr = (CW+3)'(ch * 8 + r);
    lb_data = DW'(d);
    step(0, 0);
  endtask

  task automatic frame();
    while (pos != 0) step(0, 0);
    for (int i = 0; i < NCH; i++) step(1, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    cur_in = '{1000, 2000, 0, 0};
    exp_ch = '{0, 0, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_xy", int'(out_xy), 0);
    chk("rst out_sync", int'(out_sync), 0);
    chk("rst sync_err", int'(sync_err), 0);
    rst_n = 1'b1;
    pos = 0;

    // limit clamping on ch0
    frame();
    wr(0, 3, 1500);
    frame();
    wr(0, 4, 1000);
    exp_ch[0] = 1000;
    frame();
    wr(0, 4, 0);
    frame();
    wr(0, 3, 500);
    exp_ch[0] = 500;
    frame();
    // lo > hi gives hi
    wr(0, 4, 2000);
    frame();
    wr(0, 3, 800);
    exp_ch[0] = 800;
    frame();

    // integrator ramp on ch2
    cur_in[2] = 1000;
    wr(2, 3, 3000);
    wr(2, 0, 1100);
    wr(2, 1, 65536);
    for (int k = 1; k <= 70; k++) begin
      exp_ch[2] = (50 * k > 3000) ? 3000 : 50 * k;
      frame();
    end

    // proportional and hold on ch1
    wr(1, 3, 3000);
    wr(1, 4, 500);
    exp_ch[1] = 500;
    frame();
    wr(1, 4, 0);
    frame();
    wr(1, 0, 2200);
    frame();
    wr(1, 2, 65536);
    exp_ch[1] = 600;
    frame();
    hold = 1'b1;
    wr(1, 1, 65536);
    exp_ch[1] = 700;
    repeat (3) frame();
    while (pos != 0) step(0, 0);
    hold = 1'b0;
    frame();
    exp_ch[1] = 800;
    frame();
    wr(1, 1, 0);
    wr(1, 3, 650);
    exp_ch[1] = 650;
    frame();

    // negative saturation on ch3
    cur_in[3] = 131071;
    wr(3, 4, -1000);
    wr(3, 3, 1000);
    wr(3, 0, -131072);
    wr(3, 2, 131071);
    exp_ch[3] = -1000;
    frame();
    wr(3, 1, 131071);
    frame();
    frame();

    // off-slot sync at counter 2
    while (pos != 2) step(0, 0);
    chk("sync_err idle", int'(sync_err), 0);
    step(1, 1);
    chk("sync_err pulse", int'(sync_err), 1);
    step(1, 0);
    chk("sync_err clear", int'(sync_err), 0);
    step(1, 0);
    step(1, 0);
    step(1, 0);
    chk("sync_err aligned", int'(sync_err), 0);
    step(1, 0);

    // reset mid-operation
    repeat (4) step(0, 0);
    rst_n = 1'b0;
    step(0, 0);
    rst_n = 1'b1;
    pos = 0;
    chk("mid rst out_xy", int'(out_xy), 0);
    chk("mid rst out_sync", int'(out_sync), 0);
    chk("mid rst sync_err", int'(sync_err), 0);
    step(0, 0);
    chk("post rst bubble", int'(out_xy), 0);
    exp_ch = '{0, 0, 0, 0};
    frame();
    wr(0, 3, 3000);
    frame();

    for (int i = 0; i < 8 && q.size() > 0; i++)
      step(0, 0);
    chk("scoreboard drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
